axi4_slave_mem: RTL
===================

AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 Parameter DEPTH, default 16: number of 32-bit memory words; SHALL be a power of two, from 4 to 256.
REQ-002 Parameter RD_LAT, default 0: extra idle cycles inserted between AR acceptance and the first R beat (0..15).
REQ-003 ACLK  in  1  clock; all state SHALL change on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  1/32/8/3/2  write address payload.
REQ-006 S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write address handshake.
REQ-007 S_AXI_WDATA/WSTRB/WLAST  in  32/4/1  write data payload.
REQ-008 S_AXI_WVALID in 1, S_AXI_WREADY out 1  write data handshake.
REQ-009 S_AXI_BID/BRESP  out  1/2  write response; S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-010 S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  1/32/8/3/2  read address payload.
REQ-011 S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  read address handshake.
REQ-012 S_AXI_RID/RDATA/RRESP/RLAST  out  1/32/2/1  read data; S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-013 LOCK/CACHE/PROT/QOS/REGION/USER and WID SHALL NOT be ports; the master drives them, and the block ignores them.

Function
REQ-014 The write FSM SHALL have the states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE; AW acceptance (AWVALID&AWREADY) SHALL latch ID/addr/len/size/burst and move to W_DATA.
REQ-015 WREADY=1 only in W_DATA, starting the cycle after AW acceptance; W beats arriving before AW SHALL wait (WREADY=0).
REQ-016 Each accepted W beat SHALL write the bytes enabled by WSTRB into mem[addr[2+log2(DEPTH)-1:2]] at that clock edge, unless the burst is flagged as an error.
REQ-017 Beat address: FIXED keeps the address; INCR adds 4 per beat; the word index SHALL wrap modulo DEPTH; WRAP bursts SHALL be flagged SLVERR.
REQ-018 Error flags: AWSIZE!=2 gives SLVERR (2'b10); AWADDR>=4*DEPTH gives DECERR (2'b11); flagged bursts SHALL complete all handshakes with no memory update.
REQ-019 Beat count==AWLEN SHALL end W_DATA; if WLAST disagrees with the count on any beat, the response SHALL be SLVERR unless an error is already set.
REQ-020 BVALID SHALL assert the cycle after the last W beat, with BID=latched AWID and BRESP=OKAY or the error; it SHALL be held stable until BREADY, then return to W_IDLE.
REQ-021 The read FSM SHALL have the states R_IDLE, R_WAIT, R_DATA; ARREADY=1 only in R_IDLE; on acceptance it SHALL latch the AR payload and go to R_WAIT for RD_LAT cycles, or straight to R_DATA if RD_LAT=0.
REQ-022 In R_DATA, RVALID=1; RDATA/RRESP/RLAST/RID SHALL be held stable while RVALID&!RREADY; RLAST=1 on beat ARLEN; after the last handshake the FSM returns to R_IDLE.
REQ-023 Read address stepping and error rules SHALL match REQ-017/018; error beats SHALL return RDATA=0 with RRESP=error on every beat.
REQ-024 First RDATA SHALL appear RD_LAT+1 cycles after AR acceptance; throughput SHALL be one beat per cycle while RREADY=1.
REQ-025 Read and write channels SHALL run concurrently; if a read beat and a write beat hit the same word in the same cycle, the read SHALL return the pre-write value.
REQ-026 ARLEN/AWLEN=255 (256 beats) SHALL be supported; the 8-bit beat counter SHALL NOT overflow before the last beat.

Reset
REQ-027 While rst=0: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST=0; BID, BRESP, RID, RRESP, RDATA=0; both FSMs in IDLE; all memory words=0.
REQ-028 A reset in mid-burst SHALL abandon the burst; memory words already written are cleared by the reset; AWREADY and ARREADY SHALL be 1 on the first edge after reset release.

Structure
REQ-029 The package axi4_pkg SHALL hold the BURST_FIXED/INCR/WRAP and RESP_OKAY/SLVERR/DECERR constants and the wr_state_t/rd_state_t enums.
REQ-030 Address stepping and error classification SHALL live in the sub-module axi4_addr_step, instantiated once per channel.
REQ-031 Memory SHALL be a flop array, with no vendor RAM macros.

Verification
REQ-032 Single write, addr 0x8, data 0xDEADBEEF, strb 0xF, len 0 -> BRESP=OKAY, BID=AWID; a read of 0x8 returns 0xDEADBEEF, RLAST=1.
REQ-033 INCR write, len 3, at addr 0x38 with DEPTH=16 -> words 14, 15, 0, 1 are written (wrap); a 4-beat read returns the same data in order.
REQ-034 Write 0xFFFFFFFF, then write 0x00000000 with strb 0b0101 -> a read returns 0xFF00FF00.
REQ-035 AWSIZE=1 -> BRESP=SLVERR and memory is unchanged; ARADDR=0x100 with len 2 -> 3 beats with RDATA=0 and RRESP=DECERR.
REQ-036 RD_LAT=3 with RREADY toggled randomly -> first RVALID 4 cycles after AR; RDATA stable while stalled; BVALID held across 5 cycles of BREADY=0.
REQ-037 rst pulsed mid 8-beat write -> all outputs return to their reset values; the next write/read pair completes with OKAY.

Source files
------------

// File: rtl/axi4_slave_mem_pkg.sv
// Shared AXI4 constants and FSM state types for the axi4_slave_mem block.
//   BURST_*   : AxBURST encodings
//   RESP_*    : xRESP encodings
//   wr_state_t: write channel FSM states
//   rd_state_t: read channel FSM states
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Only transfers of 4 bytes (AxSIZE=2) match the 32-bit data path.
  localparam logic [2:0] SIZE_WORD   = 3'd2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4_slave_mem_if.sv
// AXI4 slave bus bundle (single-bit IDs, 32-bit address and data).
// LOCK/CACHE/PROT/QOS/REGION/USER and WID are deliberately absent.
//   modport slave : memory side (drives READY/B/R outputs)
//   modport master: initiator side
interface axi4_slave_mem_if;
  import axi4_pkg::*;

  // Write address channel
  logic        S_AXI_AWID;
  logic [31:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic [2:0]  S_AXI_AWSIZE;
  logic [1:0]  S_AXI_AWBURST;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  // Write data channel
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  // Write response channel
  logic        S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  // Read address channel
  logic        S_AXI_ARID;
  logic [31:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic [2:0]  S_AXI_ARSIZE;
  logic [1:0]  S_AXI_ARBURST;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  // Read data channel
  logic        S_AXI_RID;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );

endinterface

// File: rtl/axi4_slave_mem_addr_step.sv
// Burst address helper, one instance per channel (purely combinational).
//   i_addr/i_size/i_burst : incoming Ax payload, classified at acceptance
//   o_resp                : OKAY, SLVERR (bad size / WRAP / reserved) or DECERR (out of range)
//   o_start_idx           : word index of the first beat
//   i_idx/i_cur_burst     : current beat index and latched burst type
//   o_next_idx            : index of the following beat (wraps modulo DEPTH)
module axi4_addr_step
  import axi4_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic [31:0]   i_addr,
  input  logic [2:0]    i_size,
  input  logic [1:0]    i_burst,
  output logic [1:0]    o_resp,
  output logic [IW-1:0] o_start_idx,
  input  logic [IW-1:0] i_idx,
  input  logic [1:0]    i_cur_burst,
  output logic [IW-1:0] o_next_idx
);

  always_comb begin
    o_resp = RESP_OKAY;
    // Decode error takes priority when several faults coincide.
    if (i_addr >= 32'(4 * DEPTH)) begin
      o_resp = RESP_DECERR;
    end else if ((i_size != SIZE_WORD) || i_burst[1]) begin
      o_resp = RESP_SLVERR;
    end
  end

  assign o_start_idx = i_addr[IW+1:2];
  // Natural IW-bit overflow provides the modulo-DEPTH wrap for INCR.
  assign o_next_idx  = (i_cur_burst == BURST_INCR) ? IW'(i_idx + 1'b1) : i_idx;

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a DEPTH x 32-bit flop array, with independent
// write (AW/W/B) and read (AR/R) FSMs running concurrently.
//   ACLK  : clock, rising edge
//   rst   : asynchronous active-low reset; clears handshakes and memory
//   s_axi : AXI4 slave modport (see axi4_slave_mem_if)
// Parameters: DEPTH (power of two, 4..256), RD_LAT (0..15 idle cycles
// between AR acceptance and the first R beat).
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned RD_LAT = 0
) (
  input  logic             ACLK,
  input  logic             rst,
  axi4_slave_mem_if.slave  s_axi
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [31:0] r_mem [DEPTH];

  // Write channel state
  wr_state_t   r_wstate;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic        r_bid;
  logic [1:0]  r_bresp;
  logic [1:0]  r_werr;
  logic [IW-1:0] r_widx;
  logic [1:0]  r_wburst;
  logic [7:0]  r_wlen;
  logic [7:0]  r_wcnt;

  // Read channel state
  rd_state_t   r_rstate;
  logic        r_arready;
  logic        r_rvalid;
  logic        r_rlast;
  logic        r_rid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;
  logic [1:0]  r_rerr;
  logic [IW-1:0] r_ridx;
  logic [1:0]  r_rburst;
  logic [7:0]  r_rlen;
  logic [7:0]  r_rcnt;
  logic [3:0]  r_lat_cnt;

  logic [1:0]    w_aw_resp;
  logic [IW-1:0] w_aw_idx;
  logic [IW-1:0] w_w_next_idx;
  logic [1:0]    w_ar_resp;
  logic [IW-1:0] w_ar_idx;
  logic [IW-1:0] w_r_next_idx;

  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_w_last;
  logic [1:0] w_w_err;
  logic       w_mem_we;
  logic       w_ar_hs;

  axi4_addr_step #(.DEPTH(DEPTH)) u_wr_step (
    .i_addr      (s_axi.S_AXI_AWADDR),
    .i_size      (s_axi.S_AXI_AWSIZE),
    .i_burst     (s_axi.S_AXI_AWBURST),
    .o_resp      (w_aw_resp),
    .o_start_idx (w_aw_idx),
    .i_idx       (r_widx),
    .i_cur_burst (r_wburst),
    .o_next_idx  (w_w_next_idx)
  );

  axi4_addr_step #(.DEPTH(DEPTH)) u_rd_step (
    .i_addr      (s_axi.S_AXI_ARADDR),
    .i_size      (s_axi.S_AXI_ARSIZE),
    .i_burst     (s_axi.S_AXI_ARBURST),
    .o_resp      (w_ar_resp),
    .o_start_idx (w_ar_idx),
    .i_idx       (r_ridx),
    .i_cur_burst (r_rburst),
    .o_next_idx  (w_r_next_idx)
  );

  assign w_aw_hs  = s_axi.S_AXI_AWVALID & r_awready;
  assign w_w_hs   = s_axi.S_AXI_WVALID & r_wready;
  assign w_w_last = (r_wcnt == r_wlen);
  // A WLAST that disagrees with the beat count only overrides a clean burst.
  assign w_w_err  = ((r_werr == RESP_OKAY) && (s_axi.S_AXI_WLAST != w_w_last)) ? RESP_SLVERR : r_werr;
  assign w_mem_we = w_w_hs & (r_werr == RESP_OKAY);
  assign w_ar_hs  = s_axi.S_AXI_ARVALID & r_arready;

  // ---------------- write FSM ----------------
  always_ff @(posedge ACLK or negedge rst) begin
    if (!rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_werr    <= RESP_OKAY;
      r_widx    <= '0;
      r_wburst  <= BURST_FIXED;
      r_wlen    <= '0;
      r_wcnt    <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= s_axi.S_AXI_AWID;
            r_werr    <= w_aw_resp;
            r_widx    <= w_aw_idx;
            r_wburst  <= s_axi.S_AXI_AWBURST;
            r_wlen    <= s_axi.S_AXI_AWLEN;
            r_wcnt    <= '0;
            r_wstate  <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_widx <= w_w_next_idx;
            r_wcnt <= r_wcnt + 8'd1;
            r_werr <= w_w_err;
            if (w_w_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_w_err;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- memory array ----------------
  always_ff @(posedge ACLK or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[IW'(i)] <= '0;
      end
    end else if (w_mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) begin
          r_mem[r_widx][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  // ---------------- read FSM ----------------
  // Each beat's data is registered at the edge that loads it, so a write to
  // the same word on that edge is not yet visible (read returns old data).
  always_ff @(posedge ACLK or negedge rst) begin
    if (!rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_rerr    <= RESP_OKAY;
      r_ridx    <= '0;
      r_rburst  <= BURST_FIXED;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_lat_cnt <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rid     <= s_axi.S_AXI_ARID;
            r_rerr    <= w_ar_resp;
            r_ridx    <= w_ar_idx;
            r_rburst  <= s_axi.S_AXI_ARBURST;
            r_rlen    <= s_axi.S_AXI_ARLEN;
            r_rcnt    <= '0;
            if (RD_LAT == 0) begin
              r_rvalid <= 1'b1;
              r_rdata  <= (w_ar_resp == RESP_OKAY) ? r_mem[w_ar_idx] : '0;
              r_rresp  <= w_ar_resp;
              r_rlast  <= (s_axi.S_AXI_ARLEN == 8'd0);
              r_rstate <= R_DATA;
            end else begin
              r_lat_cnt <= 4'(RD_LAT - 1);
              r_rstate  <= R_WAIT;
            end
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_lat_cnt == 4'd0) begin
            r_rvalid <= 1'b1;
            r_rdata  <= (r_rerr == RESP_OKAY) ? r_mem[r_ridx] : '0;
            r_rresp  <= r_rerr;
            r_rlast  <= (r_rlen == 8'd0);
            r_rstate <= R_DATA;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_ridx  <= w_r_next_idx;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rdata <= (r_rerr == RESP_OKAY) ? r_mem[w_r_next_idx] : '0;
              r_rlast <= (8'(r_rcnt + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BID     = r_bid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RLAST   = r_rlast;
  assign s_axi.S_AXI_RID     = r_rid;
  assign s_axi.S_AXI_RRESP   = r_rresp;
  assign s_axi.S_AXI_RDATA   = r_rdata;

endmodule
